// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM interface state, data word, and the responder's default latency.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   localparam int RAM_DEFAULT_LAT = 2;

endpackage

// File: rtl/ram_array.sv
// Single-port word memory with synchronous read and write.
// It has no reset, so synthesis can map it to block RAM.
module ram_array
   import cpu_types_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  word_t         wdata,
   output word_t         rdata
);

   word_t mem [2**AW];

   // Read-first: rdata shows the contents from before any write on the same edge.
   always_ff @(posedge CLK) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ram_responder.sv
// RAM responder for memory_control. It checks each request, counts down the latency,
// then gives a single ACCESS cycle, in which a read returns data and a write commits.
module ram_responder
   import cpu_types_pkg::*;
#(
   parameter int LAT = RAM_DEFAULT_LAT,
   parameter int AW  = 12
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      ramREN,
   input  logic      ramWEN,
   input  word_t     ramaddr,
   input  word_t     ramstore,
   output word_t     ramload,
   output ramstate_t ramstate
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} fsm_t;

   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   fsm_t          state, nstate;
   logic [3:0]    cnt, ncnt;
   logic          lat_ren;
   logic [AW-1:0] lat_addr;
   word_t         lat_store;
   word_t         ld_q;
   word_t         rdata;
   logic [AW-1:0] idx;
   logic          req, illegal, same, start, we, rd_fire;

   function automatic logic is_illegal(input logic ren, input logic wen, input word_t a);
      logic rq;
      rq = ren | wen;
      return (ren & wen) | (rq & (a[1:0] != 2'b00)) | (rq & (a[31:AW+2] != '0));
   endfunction

   assign idx     = ramaddr[AW+1:2];
   assign req     = ramREN | ramWEN;
   assign illegal = is_illegal(ramREN, ramWEN, ramaddr);
   // A changed op, address, or write data counts as a new request. The write data is not compared for reads.
   assign same    = (ramREN == lat_ren) && (idx == lat_addr) &&
                    (ramREN || (ramstore == lat_store));

   always_comb begin
      nstate   = state;
      ncnt     = cnt;
      start    = 1'b0;
      we       = 1'b0;
      rd_fire  = 1'b0;
      ramstate = FREE;
      if (illegal) begin
         ramstate = ERROR;
         nstate   = IDLE;
      end else if (!req) begin
         ramstate = FREE;
         nstate   = IDLE;
      end else if (state == IDLE || !same) begin
         start = 1'b1;
      end else if (state == WAIT) begin
         ramstate = BUSY;
         if (cnt <= 4'd1) begin
            nstate = DONE;
            ncnt   = 4'd0;
         end else begin
            ncnt = cnt - 4'd1;
         end
      end else begin
         ramstate = ACCESS;
         nstate   = IDLE;
         we       = !lat_ren;
         rd_fire  = lat_ren;
      end
      if (start) begin
         ramstate = BUSY;
         ncnt     = LAT_M1;
         nstate   = (LAT == 1) ? DONE : WAIT;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_ren   <= 1'b0;
         lat_addr  <= '0;
         lat_store <= '0;
         ld_q      <= '0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
         if (start) begin
            lat_ren   <= ramREN;
            lat_addr  <= idx;
            lat_store <= ramstore;
         end
         if (rd_fire) ld_q <= rdata;
      end
   end

   // The array was read on the edge into DONE, so rdata is valid during the ACCESS cycle. ld_q keeps it afterwards.
   assign ramload = rd_fire ? rdata : ld_q;

   ram_array #(.AW(AW)) u_array (
      .CLK  (CLK),
      .we   (we),
      .addr (idx),
      .wdata(lat_store),
      .rdata(rdata)
   );

endmodule
